// File: rtl/udp_iq_depacketizer.sv
//==============================================================================
// Module      : udp_iq_depacketizer
// Description : Parses Ethernet/IPv4/UDP IQ frames from a MAC RX byte stream,
//               writes {I,Q} words to a FIFO and reports sequence gaps.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module udp_iq_depacketizer #(
    parameter logic [47:0] LOCAL_MAC     = 48'h021234567890,
    parameter logic [31:0] LOCAL_IP      = {8'd10, 8'd0, 8'd0, 8'd2},
    parameter logic [15:0] LOCAL_PORT    = 16'd32179,
    parameter int          PAYLOAD_WORDS = 366
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_dval,
    input  logic        rx_sop,
    input  logic        rx_eop,
    input  logic        rx_err,
    output logic        wr_en,
    output logic [31:0] wr_data,
    input  logic        wr_full,
    output logic        seq_gap,
    output logic        overflow,
    output logic        frame_err,
    output logic [31:0] frames_ok,
    output logic [31:0] frames_drop
);

    localparam logic [10:0] c_SEQ_FIRST = 11'd42;
    localparam logic [10:0] c_SEQ_LAST  = 11'd49;
    localparam logic [10:0] c_PAY_START = 11'd50;
    localparam logic [10:0] c_LAST_BYTE = 11'(50 + 4 * PAYLOAD_WORDS - 1);
    localparam logic [15:0] c_UDP_LEN   = 16'(16 + 4 * PAYLOAD_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_PAY  = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [10:0] r_cnt, w_cnt_nxt, w_idx;
    logic        r_uc, r_bc, w_uc_nxt, w_bc_nxt;
    logic [63:0] r_seq, w_seq_nxt;
    logic [63:0] r_exp, w_exp_nxt;
    logic        r_exp_vld, w_exp_vld_nxt;
    logic [7:0]  r_i_lo, r_i_hi, r_q_lo, w_i_lo_nxt, w_i_hi_nxt, w_q_lo_nxt;
    logic [31:0] r_wr_data, w_wr_data_nxt;
    logic        r_wr_en, r_seq_gap, r_overflow, r_frame_err;
    logic [31:0] r_frames_ok, r_frames_drop;
    logic        w_wr, w_ovf, w_ferr, w_gap, w_ok_inc, w_mis, w_active;
    logic [1:0]  w_drop_inc, w_pos;
    logic [7:0]  w_mac_byte;
    logic [32:0] w_drop_sum;

    always_comb begin
        w_mac_byte = 8'h00;
        case (w_idx[2:0])
            3'd0:    w_mac_byte = LOCAL_MAC[47:40];
            3'd1:    w_mac_byte = LOCAL_MAC[39:32];
            3'd2:    w_mac_byte = LOCAL_MAC[31:24];
            3'd3:    w_mac_byte = LOCAL_MAC[23:16];
            3'd4:    w_mac_byte = LOCAL_MAC[15:8];
            default: w_mac_byte = LOCAL_MAC[7:0];
        endcase
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_uc_nxt      = r_uc;
        w_bc_nxt      = r_bc;
        w_seq_nxt     = r_seq;
        w_exp_nxt     = r_exp;
        w_exp_vld_nxt = r_exp_vld;
        w_i_lo_nxt    = r_i_lo;
        w_i_hi_nxt    = r_i_hi;
        w_q_lo_nxt    = r_q_lo;
        w_wr_data_nxt = r_wr_data;
        w_wr          = 1'b0;
        w_ovf         = 1'b0;
        w_ferr        = 1'b0;
        w_gap         = 1'b0;
        w_ok_inc      = 1'b0;
        w_mis         = 1'b0;
        w_drop_inc    = 2'd0;
        w_idx         = rx_sop ? 11'd0 : r_cnt;
        w_pos         = w_idx[1:0] + 2'd2;   // (idx - 50) mod 4
        w_active      = rx_sop || (r_state == S_HDR) || (r_state == S_PAY);

        if (rx_dval) begin
            // A new SOP while a frame is still being parsed abandons that frame.
            if (rx_sop && ((r_state == S_HDR) || (r_state == S_PAY))) begin
                w_ferr     = 1'b1;
                w_drop_inc = 2'd1;
            end

            if (w_active) begin
                w_cnt_nxt   = w_idx + 11'd1;
                w_state_nxt = (w_idx >= c_SEQ_LAST) ? S_PAY : S_HDR;

                case (w_idx)
                    11'd0, 11'd1, 11'd2, 11'd3, 11'd4, 11'd5: begin
                        w_uc_nxt = ((w_idx == 11'd0) || r_uc) && (rx_data == w_mac_byte);
                        w_bc_nxt = ((w_idx == 11'd0) || r_bc) && (rx_data == 8'hFF);
                        w_mis    = !(w_uc_nxt || w_bc_nxt);
                    end
                    11'd12:  w_mis = (rx_data != 8'h08);
                    11'd13:  w_mis = (rx_data != 8'h00);
                    11'd14:  w_mis = (rx_data != 8'h45);
                    11'd23:  w_mis = (rx_data != 8'h11);
                    11'd30:  w_mis = (rx_data != LOCAL_IP[31:24]);
                    11'd31:  w_mis = (rx_data != LOCAL_IP[23:16]);
                    11'd32:  w_mis = (rx_data != LOCAL_IP[15:8]);
                    11'd33:  w_mis = (rx_data != LOCAL_IP[7:0]);
                    11'd36:  w_mis = (rx_data != LOCAL_PORT[15:8]);
                    11'd37:  w_mis = (rx_data != LOCAL_PORT[7:0]);
                    11'd38:  w_mis = (rx_data != c_UDP_LEN[15:8]);
                    11'd39:  w_mis = (rx_data != c_UDP_LEN[7:0]);
                    default: w_mis = 1'b0;
                endcase

                // Sequence counter arrives LSB first; shift in from the top.
                if ((w_idx >= c_SEQ_FIRST) && (w_idx <= c_SEQ_LAST)) begin
                    w_seq_nxt = {rx_data, r_seq[63:8]};
                    if (w_idx == c_SEQ_LAST) begin
                        w_gap         = r_exp_vld && (w_seq_nxt != r_exp);
                        w_exp_nxt     = w_seq_nxt + 64'd1;
                        w_exp_vld_nxt = 1'b1;
                    end
                end

                if ((w_idx >= c_PAY_START) && (w_idx <= c_LAST_BYTE)) begin
                    case (w_pos)
                        2'd0: w_i_lo_nxt = rx_data;
                        2'd1: w_i_hi_nxt = rx_data;
                        2'd2: w_q_lo_nxt = rx_data;
                        default: begin
                            if (wr_full) begin
                                w_ovf = 1'b1;
                            end else begin
                                w_wr          = 1'b1;
                                w_wr_data_nxt = {r_i_hi, r_i_lo, rx_data, r_q_lo};
                            end
                        end
                    endcase
                end

                if (w_mis) begin
                    w_drop_inc  = w_drop_inc + 2'd1;
                    w_state_nxt = rx_eop ? S_IDLE : S_DROP;
                end else if (rx_eop) begin
                    if ((w_idx == c_LAST_BYTE) && !rx_err) begin
                        w_ok_inc = 1'b1;
                    end else begin
                        w_ferr     = 1'b1;
                        w_drop_inc = w_drop_inc + 2'd1;
                    end
                    w_state_nxt = S_IDLE;
                end else if (w_idx > c_LAST_BYTE) begin
                    w_ferr      = 1'b1;
                    w_drop_inc  = w_drop_inc + 2'd1;
                    w_state_nxt = S_DROP;
                end
            end else if ((r_state == S_DROP) && rx_eop) begin
                w_state_nxt = S_IDLE;
            end
        end
    end

    assign w_drop_sum = {1'b0, r_frames_drop} + {31'd0, w_drop_inc};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= 11'd0;
            r_uc          <= 1'b0;
            r_bc          <= 1'b0;
            r_seq         <= 64'd0;
            r_exp         <= 64'd0;
            r_exp_vld     <= 1'b0;
            r_i_lo        <= 8'd0;
            r_i_hi        <= 8'd0;
            r_q_lo        <= 8'd0;
            r_wr_data     <= 32'd0;
            r_wr_en       <= 1'b0;
            r_seq_gap     <= 1'b0;
            r_overflow    <= 1'b0;
            r_frame_err   <= 1'b0;
            r_frames_ok   <= 32'd0;
            r_frames_drop <= 32'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_uc          <= w_uc_nxt;
            r_bc          <= w_bc_nxt;
            r_seq         <= w_seq_nxt;
            r_exp         <= w_exp_nxt;
            r_exp_vld     <= w_exp_vld_nxt;
            r_i_lo        <= w_i_lo_nxt;
            r_i_hi        <= w_i_hi_nxt;
            r_q_lo        <= w_q_lo_nxt;
            r_wr_data     <= w_wr_data_nxt;
            r_wr_en       <= w_wr;
            r_seq_gap     <= w_gap;
            r_overflow    <= w_ovf;
            r_frame_err   <= w_ferr;
            if (w_ok_inc && (r_frames_ok != 32'hFFFF_FFFF)) begin
                r_frames_ok <= r_frames_ok + 32'd1;
            end
            r_frames_drop <= w_drop_sum[32] ? 32'hFFFF_FFFF : w_drop_sum[31:0];
        end
    end

    assign wr_en       = r_wr_en;
    assign wr_data     = r_wr_data;
    assign seq_gap     = r_seq_gap;
    assign overflow    = r_overflow;
    assign frame_err   = r_frame_err;
    assign frames_ok   = r_frames_ok;
    assign frames_drop = r_frames_drop;

endmodule

`default_nettype wire

// File: tb/tb_udp_iq_depacketizer.sv
//==============================================================================
// Module      : tb_udp_iq_depacketizer
// Description : Directed self-checking bench for udp_iq_depacketizer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_udp_iq_depacketizer;

    localparam logic [47:0] c_MAC   = 48'h021234567890;
    localparam logic [47:0] c_BCAST = 48'hFFFFFFFFFFFF;
    localparam logic [15:0] c_PORT  = 16'd32179;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_dval, rx_sop, rx_eop, rx_err;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        wr_full;
    logic        seq_gap, overflow, frame_err;
    logic [31:0] frames_ok, frames_drop;

    always #5 clk = ~clk;

    udp_iq_depacketizer dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_dval     (rx_dval),
        .rx_sop      (rx_sop),
        .rx_eop      (rx_eop),
        .rx_err      (rx_err),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .wr_full     (wr_full),
        .seq_gap     (seq_gap),
        .overflow    (overflow),
        .frame_err   (frame_err),
        .frames_ok   (frames_ok),
        .frames_drop (frames_drop)
    );

    int total = 0;
    int bad   = 0;
    int n_wr, n_gap, n_ovf, n_ferr, data_bad, gap_frame, cur_frame;
    logic [31:0] exp_q[$];
    logic [31:0] first_word;
    bit          first_seen;

    // Output monitor, sampled 1 time unit after the active edge.
    always @(posedge clk) begin
        #1;
        if (wr_en === 1'b1) begin
            if (!first_seen) begin
                first_word = wr_data;
                first_seen = 1'b1;
            end
            if (exp_q.size() == 0) begin
                data_bad++;
            end else begin
                if (exp_q[0] !== wr_data) data_bad++;
                void'(exp_q.pop_front());
            end
            n_wr++;
        end
        if (seq_gap === 1'b1) begin
            n_gap++;
            gap_frame = cur_frame;
        end
        if (overflow === 1'b1) n_ovf++;
        if (frame_err === 1'b1) n_ferr++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_tb();
        n_wr = 0; n_gap = 0; n_ovf = 0; n_ferr = 0; data_bad = 0;
        gap_frame = 0; cur_frame = 0; first_seen = 1'b0; first_word = 32'd0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1; rx_data = 8'd0; rx_dval = 1'b0; rx_sop = 1'b0;
        rx_eop = 1'b0; rx_err = 1'b0; wr_full = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_tb();
    endtask

    function automatic logic [7:0] fbyte(input int i, input logic [47:0] mac,
                                         input logic [15:0] port, input logic [63:0] seq);
        logic [31:0] ip;
        logic [15:0] n;
        int w;
        ip = {8'd10, 8'd0, 8'd0, 8'd2};
        if (i < 6) return mac[8*(5-i) +: 8];
        if (i >= 42 && i < 50) return seq[8*(i-42) +: 8];
        if (i >= 50) begin
            w = (i - 50) / 4;
            n = w[15:0];
            case ((i - 50) % 4)
                0:       return n[7:0];
                1:       return n[15:8];
                2:       return ~n[7:0];
                default: return ~n[15:8];
            endcase
        end
        case (i)
            12:      return 8'h08;
            13:      return 8'h00;
            14:      return 8'h45;
            23:      return 8'h11;
            30:      return ip[31:24];
            31:      return ip[23:16];
            32:      return ip[15:8];
            33:      return ip[7:0];
            36:      return port[15:8];
            37:      return port[7:0];
            38:      return 8'h05;
            39:      return 8'hC8;
            default: return 8'hA5;
        endcase
    endfunction

    // Drives bytes 0..last; rst_at >= 0 pulses rst in place of that byte and stops.
    task automatic send_frame(input logic [47:0] mac, input logic [15:0] port,
                              input logic [63:0] seq, input int last, input int rst_at,
                              input int full_lo, input int full_hi);
        int w;
        logic [15:0] n;
        for (int i = 0; i <= last; i++) begin
            if (i == rst_at) begin
                rx_dval = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0; rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (i % 97 == 5) begin
                rx_dval = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0; rx_data = 8'h00;
                @(negedge clk);
            end
            w = (i >= 50) ? (i - 50) / 4 : -100;
            n = w[15:0];
            rx_data = fbyte(i, mac, port, seq);
            rx_dval = 1'b1;
            rx_sop  = (i == 0);
            rx_eop  = (i == last);
            rx_err  = 1'b0;
            wr_full = (i >= 50) && (w >= full_lo) && (w <= full_hi);
            if (i >= 50 && i <= 1513 && (i - 50) % 4 == 3 && !wr_full)
                exp_q.push_back({n, ~n});
            @(negedge clk);
        end
        rx_dval = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0; wr_full = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        do_reset();
        check("rst_wr_en",       wr_en,       0);
        check("rst_seq_gap",     seq_gap,     0);
        check("rst_overflow",    overflow,    0);
        check("rst_frame_err",   frame_err,   0);
        check("rst_frames_ok",   frames_ok,   0);
        check("rst_frames_drop", frames_drop, 0);

        // 1: one valid frame, seq 0
        send_frame(c_MAC, c_PORT, 64'd0, 1513, -1, -1, -1);
        check("t1_writes",     n_wr,        366);
        check("t1_first_word", first_word,  32'h0000FFFF);
        check("t1_data",       data_bad,    0);
        check("t1_frames_ok",  frames_ok,   1);
        check("t1_drop",       frames_drop, 0);
        check("t1_gap",        n_gap,       0);
        check("t1_ferr",       n_ferr,      0);

        // 2: sequence 5, 6, 8 -> one gap in frame 3
        do_reset();
        cur_frame = 1; send_frame(c_MAC, c_PORT, 64'd5, 1513, -1, -1, -1);
        cur_frame = 2; send_frame(c_MAC, c_PORT, 64'd6, 1513, -1, -1, -1);
        cur_frame = 3; send_frame(c_MAC, c_PORT, 64'd8, 1513, -1, -1, -1);
        check("t2_gap_count", n_gap,     1);
        check("t2_gap_frame", gap_frame, 3);
        check("t2_frames_ok", frames_ok, 3);
        check("t2_writes",    n_wr,      1098);
        check("t2_data",      data_bad,  0);

        // 3: wrong UDP port dropped, then broadcast-addressed frame accepted
        do_reset();
        send_frame(c_MAC, 16'd1234, 64'd0, 1513, -1, -1, -1);
        check("t3_drop_writes", n_wr,        0);
        check("t3_drop_count",  frames_drop, 1);
        check("t3_drop_ok",     frames_ok,   0);
        clear_tb();
        send_frame(c_BCAST, c_PORT, 64'd0, 1513, -1, -1, -1);
        check("t3_bc_writes", n_wr,        366);
        check("t3_bc_ok",     frames_ok,   1);
        check("t3_bc_drop",   frames_drop, 1);
        check("t3_bc_data",   data_bad,    0);

        // 4: truncated at byte 800
        do_reset();
        send_frame(c_MAC, c_PORT, 64'd0, 800, -1, -1, -1);
        check("t4_writes", n_wr,        187);
        check("t4_ferr",   n_ferr,      1);
        check("t4_drop",   frames_drop, 1);
        check("t4_ok",     frames_ok,   0);
        check("t4_data",   data_bad,    0);

        // 5: FIFO full during words 10..12
        do_reset();
        send_frame(c_MAC, c_PORT, 64'd0, 1513, -1, 10, 12);
        check("t5_overflow", n_ovf,     3);
        check("t5_writes",   n_wr,      363);
        check("t5_ok",       frames_ok, 1);
        check("t5_data",     data_bad,  0);

        // 6: reset mid-frame clears counters and the expected sequence
        do_reset();
        send_frame(c_MAC, c_PORT, 64'd7, 1513, -1, -1, -1);
        check("t6_pre_ok", frames_ok, 1);
        send_frame(c_MAC, c_PORT, 64'd8, 1513, 600, -1, -1);
        #1;
        check("t6_rst_ok",    frames_ok,   0);
        check("t6_rst_wr_en", wr_en,       0);
        @(negedge clk);
        clear_tb();
        send_frame(c_MAC, c_PORT, 64'd0, 1513, -1, -1, -1);
        check("t6_writes", n_wr,        366);
        check("t6_gap",    n_gap,       0);
        check("t6_ok",     frames_ok,   1);
        check("t6_drop",   frames_drop, 0);

        // 7: overlong frame (eop on byte 1514)
        do_reset();
        send_frame(c_MAC, c_PORT, 64'd0, 1514, -1, -1, -1);
        check("t7_writes", n_wr,        366);
        check("t7_ferr",   n_ferr,      1);
        check("t7_drop",   frames_drop, 1);
        check("t7_ok",     frames_ok,   0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
